boreal_hid_packet_rx: RTL and testbench
=======================================

// Module: boreal_hid_packet_rx
// PURPOSE
//   Host-side receiver for the cursor core's uart_tx HID packet stream.
//   Deserialises 8N1 UART bytes, frames fixed 8-byte packets, verifies the checksum and presents decoded dx/dy/buttons/seq.
//   Used as the loopback checker in full-stack benches and as the FPGA-side bridge to a host HID endpoint.
// PARAMETERS
//   CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 8
//   TIMEOUT_BITS  20   idle bit-periods mid-packet before the framer drops the partial packet
// PORTS
//   clk            in   1   system clock, single domain
//   rst_n          in   1   asynchronous active-low reset
//   uart_rx        in   1   serial line, idle high, asynchronous to clk
//   pkt_valid      out  1   one-cycle pulse: a new good packet is on pkt_*
//   pkt_dx         out  16  signed cursor delta X
//   pkt_dy         out  16  signed cursor delta Y
//   pkt_buttons    out  8   bit0 = left, bit1 = right, others reserved
//   pkt_seq        out  8   packet sequence number
//   seq_gap        out  1   qualified by pkt_valid: sequence discontinuity
//   csum_err_cnt   out  16  saturating count of checksum failures
//   frame_err_cnt  out  16  saturating count of bad stop bits
//   rx_busy        out  1   high while the framer is outside HUNT
// BEHAVIOUR
//   Reset: all outputs 0. Framer in HUNT, byte FSM in IDLE, first_pkt flag = 1.
//   Input: uart_rx passes through a 2-flop synchroniser and is reset to 1. All sampling uses the synchronised signal.
//   Byte FSM (IDLE, START, DATA, STOP):
//     - IDLE -> START on a synced falling level (0).
//     - START: at count CLKS_PER_BIT/2, line 0 -> DATA. Line 1 -> IDLE (glitch reject, no count).
//     - DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first.
//     - STOP: sample once after CLKS_PER_BIT. Line 1: byte_valid pulses the next cycle. Line 0: frame_err_cnt++ and framer forced to HUNT.
//     - STOP returns to IDLE straight after the sample, giving half a bit of resync margin.
//   Packet format, bytes 0..7:
//     - A5 | DX_L DX_H | DY_L DY_H | BTN | SEQ | CSUM.
//     - CSUM = (sum of bytes 1..6) mod 256.
//   Framer (HUNT, COLLECT, CHECK):
//     - HUNT discards any byte other than 0xA5. 0xA5 -> COLLECT, index = 1, running sum = 0.
//     - COLLECT stores bytes 1..6 and accumulates an 8-bit wrap sum. 0xA5 inside the payload is data, not a resync.
//     - On byte 7 -> CHECK for one cycle. Match: latch pkt_*, pulse pkt_valid. Mismatch: csum_err_cnt++ and pkt_* hold old values.
//     - CHECK always returns to HUNT.
//   Latency: pkt_valid is high 2 clk after the CSUM stop-bit sample edge (byte_valid +1).
//   Sequence check:
//     - seq_gap = !first_pkt && (seq != last_seq + 1, mod 256); 0xFF -> 0x00 is not a gap.
//     - first_pkt clears on the first good packet. last_seq updates on good packets only.
//   Timeout: COLLECT with no byte_valid for TIMEOUT_BITS*CLKS_PER_BIT cycles -> HUNT, with no counter change.
//   Counters saturate at 0xFFFF, with no wrap.
//   Reset asserted mid-byte or mid-packet: immediate return to the reset state. The next packet after release decodes normally.
// STRUCTURE
//   Package boreal_pkt_pkg holds:
//     - SYNC_BYTE = 8'hA5, PKT_LEN = 8.
//     - Byte-index localparams (IDX_DX_L..IDX_CSUM).
//     - State encodings.
//     - Function pkt_csum(bytes 1..6).
//   The cursor-core transmitter uses the same package.
//   Sub-module boreal_uart_rx_byte contains the synchroniser, byte FSM and frame error. Its outputs are byte_valid, byte_data and frame_err.
//   The framer, seq check and counters live in the top.
// TESTING (benches use CLKS_PER_BIT = 16)
//   1. Good packet dx=0x0123, dy=0xFF9C, btn=0x01, seq=0x05, CSUM=0xC5 -> one pkt_valid, pkt_dy = -100, seq_gap = 0 (first packet).
//   2. Same packet with CSUM=0xC6 -> no pkt_valid, csum_err_cnt = 1, pkt_* unchanged.
//   3. Stop bit forced 0 on byte 3 -> frame_err_cnt = 1, framer in HUNT. The following good packet decodes.
//   4. Seq stream 0xFE, 0xFF, 0x00, 0x02 -> seq_gap = 0, 0, 1 on the 2nd-4th packets (1 only on the seq=0x02 packet).
//   5. 0x00 0x7A bytes preceding A5, and a payload containing 0xA5 -> junk ignored, exactly one correct decode.
//   6. Line held idle 25 bit-times after 4 bytes, then a full packet -> partial dropped, new packet valid, no counter change.
//   7. 3-cycle low glitch on uart_rx -> no byte decoded. rst_n pulsed mid-packet -> all outputs 0, the next packet decodes.

Source files
------------

// File: rtl/boreal_pkt_pkg.sv
// Shared definitions for the boreal HID packet link: framing constants,
// byte positions, state encodings and the packet checksum.
package boreal_pkt_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         PKT_LEN   = 8;

   localparam logic [2:0] IDX_DX_L = 3'd1;
   localparam logic [2:0] IDX_DX_H = 3'd2;
   localparam logic [2:0] IDX_DY_L = 3'd3;
   localparam logic [2:0] IDX_DY_H = 3'd4;
   localparam logic [2:0] IDX_BTN  = 3'd5;
   localparam logic [2:0] IDX_SEQ  = 3'd6;
   localparam logic [2:0] IDX_CSUM = 3'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      BYTE_IDLE,
      BYTE_START,
      BYTE_DATA,
      BYTE_STOP
   } byte_state_e;

   typedef enum logic [1:0] {
      FR_HUNT,
      FR_COLLECT,
      FR_CHECK
   } frame_state_e;

   // payload[7:0] is packet byte 1, payload[47:40] is packet byte 6
   function automatic logic [7:0] pkt_csum(input logic [47:0] payload);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 6; i++) begin
         s = s + payload[i*8 +: 8];
      end
      return s;
   endfunction

endpackage

// File: rtl/boreal_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling FSM,
// one-cycle byte_valid / frame_err pulses.
module boreal_uart_rx_byte
   import boreal_pkt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       uart_rx_i,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  FULL_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

   logic          sync1_q, sync2_q;
   byte_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          rx_s;

   assign rx_s = sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         BYTE_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = BYTE_START;
         end
         BYTE_START: begin
            // A start bit that is gone by mid-bit was a glitch.
            if (cnt_q == HALF_CNT) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = rx_s ? BYTE_IDLE : BYTE_DATA;
            end
         end
         BYTE_DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = BYTE_STOP;
            end
         end
         BYTE_STOP: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               valid_d = rx_s;
               ferr_d  = !rx_s;
               state_d = BYTE_IDLE;
            end
         end
         default: state_d = BYTE_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= BYTE_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= uart_rx_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign byte_valid_o = valid_q;
   assign byte_data_o  = shift_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: rtl/boreal_hid_packet_rx.sv
// Host-side HID packet receiver: frames 8-byte A5-led packets from the UART
// byte stream, verifies the checksum, tracks sequence gaps and error counts.
module boreal_hid_packet_rx
   import boreal_pkt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic        pkt_valid,
   output logic [15:0] pkt_dx,
   output logic [15:0] pkt_dy,
   output logic [7:0]  pkt_buttons,
   output logic [7:0]  pkt_seq,
   output logic        seq_gap,
   output logic [15:0] csum_err_cnt,
   output logic [15:0] frame_err_cnt,
   output logic        rx_busy
);

   localparam int            TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int            TW         = $clog2(TMO_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYCLES - 1);

   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         frame_err;

   frame_state_e state_q, state_d;
   logic [2:0]   idx_q;
   logic [7:0]   sum_q;
   logic [TW-1:0] tmo_q;
   logic [15:0]  dx_q, dy_q;
   logic [7:0]   btn_q, seq_q, csum_q;
   logic         first_q;
   logic [7:0]   last_seq_q;
   logic         tmo_hit, csum_ok;
   logic [7:0]   next_seq;

   boreal_uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .uart_rx_i   (uart_rx),
      .byte_valid_o(byte_valid),
      .byte_data_o (byte_data),
      .frame_err_o (frame_err)
   );

   assign tmo_hit  = (tmo_q == TMO_LAST);
   assign csum_ok  = (csum_q == sum_q);
   assign next_seq = last_seq_q + 8'd1;
   assign rx_busy  = (state_q != FR_HUNT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         FR_HUNT:    if (byte_valid && byte_data == SYNC_BYTE) state_d = FR_COLLECT;
         FR_COLLECT: begin
            if (byte_valid && idx_q == IDX_CSUM) state_d = FR_CHECK;
            else if (tmo_hit)                    state_d = FR_HUNT;
         end
         FR_CHECK:   state_d = FR_HUNT;
         default:    state_d = FR_HUNT;
      endcase
      if (frame_err) state_d = FR_HUNT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FR_HUNT;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q         <= IDX_DX_L;
         sum_q         <= 8'h00;
         tmo_q         <= '0;
         dx_q          <= 16'h0000;
         dy_q          <= 16'h0000;
         btn_q         <= 8'h00;
         seq_q         <= 8'h00;
         csum_q        <= 8'h00;
         first_q       <= 1'b1;
         last_seq_q    <= 8'h00;
         pkt_valid     <= 1'b0;
         pkt_dx        <= 16'h0000;
         pkt_dy        <= 16'h0000;
         pkt_buttons   <= 8'h00;
         pkt_seq       <= 8'h00;
         seq_gap       <= 1'b0;
         csum_err_cnt  <= 16'h0000;
         frame_err_cnt <= 16'h0000;
      end else begin
         pkt_valid <= 1'b0;

         if (state_q == FR_COLLECT && !byte_valid) tmo_q <= tmo_q + TW'(1);
         else                                      tmo_q <= '0;

         if (state_q == FR_HUNT) begin
            idx_q <= IDX_DX_L;
            sum_q <= 8'h00;
         end

         // Inside the payload every byte is data, including 0xA5.
         if (state_q == FR_COLLECT && byte_valid) begin
            idx_q <= idx_q + 3'd1;
            if (idx_q != IDX_CSUM) sum_q <= sum_q + byte_data;
            case (idx_q)
               IDX_DX_L: dx_q[7:0]  <= byte_data;
               IDX_DX_H: dx_q[15:8] <= byte_data;
               IDX_DY_L: dy_q[7:0]  <= byte_data;
               IDX_DY_H: dy_q[15:8] <= byte_data;
               IDX_BTN:  btn_q      <= byte_data;
               IDX_SEQ:  seq_q      <= byte_data;
               IDX_CSUM: csum_q     <= byte_data;
               default: ;
            endcase
         end

         if (state_q == FR_CHECK) begin
            if (csum_ok) begin
               pkt_valid   <= 1'b1;
               pkt_dx      <= dx_q;
               pkt_dy      <= dy_q;
               pkt_buttons <= btn_q;
               pkt_seq     <= seq_q;
               seq_gap     <= !first_q && (seq_q != next_seq);
               first_q     <= 1'b0;
               last_seq_q  <= seq_q;
            end else if (csum_err_cnt != 16'hFFFF) begin
               csum_err_cnt <= csum_err_cnt + 16'd1;
            end
         end

         if (frame_err && frame_err_cnt != 16'hFFFF) begin
            frame_err_cnt <= frame_err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_boreal_hid_packet_rx.sv
// Directed bench for boreal_hid_packet_rx at 16 clocks per UART bit.
module tb_boreal_hid_packet_rx;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rx = 1'b1;
   logic        pkt_valid;
   logic [15:0] pkt_dx, pkt_dy;
   logic [7:0]  pkt_buttons, pkt_seq;
   logic        seq_gap;
   logic [15:0] csum_err_cnt, frame_err_cnt;
   logic        rx_busy;

   int n_cmp = 0;
   int n_bad = 0;
   int pv_cnt = 0;
   logic gap_cap = 1'b0;

   always #5 clk = ~clk;

   boreal_hid_packet_rx #(
      .CLKS_PER_BIT(CPB),
      .TIMEOUT_BITS(20)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .pkt_valid    (pkt_valid),
      .pkt_dx       (pkt_dx),
      .pkt_dy       (pkt_dy),
      .pkt_buttons  (pkt_buttons),
      .pkt_seq      (pkt_seq),
      .seq_gap      (seq_gap),
      .csum_err_cnt (csum_err_cnt),
      .frame_err_cnt(frame_err_cnt),
      .rx_busy      (rx_busy)
   );

   // Count pulses and capture seq_gap while it is qualified.
   always @(negedge clk) begin
      if (pkt_valid) begin
         pv_cnt  = pv_cnt + 1;
         gap_cap = seq_gap;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_bits(input int n);
      uart_rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   function automatic logic [7:0] model_csum(input logic [15:0] dx, input logic [15:0] dy,
                                             input logic [7:0] btn, input logic [7:0] seq);
      logic [7:0] s;
      s = dx[7:0] + dx[15:8] + dy[7:0] + dy[15:8] + btn + seq;
      return s;
   endfunction

   task automatic send_pkt(input logic [15:0] dx, input logic [15:0] dy, input logic [7:0] btn,
                           input logic [7:0] seq, input logic [7:0] flip);
      send_byte(8'hA5, 1'b1);
      send_byte(dx[7:0], 1'b1);
      send_byte(dx[15:8], 1'b1);
      send_byte(dy[7:0], 1'b1);
      send_byte(dy[15:8], 1'b1);
      send_byte(btn, 1'b1);
      send_byte(seq, 1'b1);
      send_byte(model_csum(dx, dy, btn, seq) ^ flip, 1'b1);
      idle_bits(2);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, pkt_valid, 0);
      chk({tag, "_dx"}, pkt_dx, 0);
      chk({tag, "_dy"}, pkt_dy, 0);
      chk({tag, "_btn"}, pkt_buttons, 0);
      chk({tag, "_seq"}, pkt_seq, 0);
      chk({tag, "_gap"}, seq_gap, 0);
      chk({tag, "_csum_cnt"}, csum_err_cnt, 0);
      chk({tag, "_frame_cnt"}, frame_err_cnt, 0);
      chk({tag, "_busy"}, rx_busy, 0);
   endtask

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;
      idle_bits(2);
      chk("rst_idle_busy", rx_busy, 0);

      // 1: first good packet
      send_pkt(16'h0123, 16'hFF9C, 8'h01, 8'h05, 8'h00);
      chk("t1_pv", pv_cnt, 1);
      chk("t1_dx", pkt_dx, 32'h0123);
      chk("t1_dy", pkt_dy, 32'hFF9C);
      chk("t1_btn", pkt_buttons, 32'h01);
      chk("t1_seq", pkt_seq, 32'h05);
      chk("t1_gap", gap_cap, 0);
      chk("t1_busy", rx_busy, 0);

      // 2: same packet, CSUM 0xC6 instead of 0xC5
      send_pkt(16'h0123, 16'hFF9C, 8'h01, 8'h05, 8'h03);
      chk("t2_pv", pv_cnt, 1);
      chk("t2_csum_cnt", csum_err_cnt, 1);
      chk("t2_dx_hold", pkt_dx, 32'h0123);
      chk("t2_seq_hold", pkt_seq, 32'h05);

      // 3: bad stop bit on byte 3, then a good packet
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      idle_bits(2);
      chk("t3_frame_cnt", frame_err_cnt, 1);
      chk("t3_busy", rx_busy, 0);
      chk("t3_pv_none", pv_cnt, 1);
      send_pkt(16'h0002, 16'h0003, 8'h02, 8'h06, 8'h00);
      chk("t3_pv", pv_cnt, 2);
      chk("t3_dx", pkt_dx, 32'h0002);
      chk("t3_seq", pkt_seq, 32'h06);
      chk("t3_gap", gap_cap, 0);

      // 4: sequence stream FE, FF, 00, 02 after 06
      send_pkt(16'h0001, 16'h0001, 8'h00, 8'hFE, 8'h00);
      chk("t4_fe_gap", gap_cap, 1);
      send_pkt(16'h0001, 16'h0001, 8'h00, 8'hFF, 8'h00);
      chk("t4_ff_gap", gap_cap, 0);
      send_pkt(16'h0001, 16'h0001, 8'h00, 8'h00, 8'h00);
      chk("t4_00_gap", gap_cap, 0);
      chk("t4_00_seq", pkt_seq, 32'h00);
      send_pkt(16'h0001, 16'h0001, 8'h00, 8'h02, 8'h00);
      chk("t4_02_gap", gap_cap, 1);
      chk("t4_pv", pv_cnt, 6);

      // 5: junk before sync, 0xA5 inside the payload
      send_byte(8'h00, 1'b1);
      send_byte(8'h7A, 1'b1);
      send_pkt(16'h00A5, 16'h1234, 8'h02, 8'h03, 8'h00);
      chk("t5_pv", pv_cnt, 7);
      chk("t5_dx", pkt_dx, 32'h00A5);
      chk("t5_dy", pkt_dy, 32'h1234);
      chk("t5_btn", pkt_buttons, 32'h02);
      chk("t5_gap", gap_cap, 0);
      chk("t5_csum_cnt", csum_err_cnt, 1);

      // 6: partial packet times out, next packet decodes
      send_byte(8'hA5, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      idle_bits(25);
      chk("t6_busy", rx_busy, 0);
      send_pkt(16'hFFFF, 16'h0000, 8'h00, 8'h04, 8'h00);
      chk("t6_pv", pv_cnt, 8);
      chk("t6_dx", pkt_dx, 32'hFFFF);
      chk("t6_seq", pkt_seq, 32'h04);
      chk("t6_csum_cnt", csum_err_cnt, 1);
      chk("t6_frame_cnt", frame_err_cnt, 1);

      // 7a: short low glitch in the middle of a packet is ignored
      send_byte(8'hA5, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      idle_bits(3);
      send_byte(8'h20, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(model_csum(16'h0010, 16'h0020, 8'h00, 8'h05), 1'b1);
      idle_bits(2);
      chk("t7_glitch_pv", pv_cnt, 9);
      chk("t7_glitch_dy", pkt_dy, 32'h0020);
      chk("t7_glitch_csum_cnt", csum_err_cnt, 1);

      // 7b: reset pulsed mid-byte of a partial packet
      send_byte(8'hA5, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("t7_rst");
      uart_rx = 1'b1;
      rst_n = 1'b1;
      idle_bits(2);
      send_pkt(16'h7FFF, 16'h8000, 8'h03, 8'h40, 8'h00);
      chk("t7_pv", pv_cnt, 10);
      chk("t7_dx", pkt_dx, 32'h7FFF);
      chk("t7_dy", pkt_dy, 32'h8000);
      chk("t7_btn", pkt_buttons, 32'h03);
      chk("t7_seq", pkt_seq, 32'h40);
      chk("t7_gap", gap_cap, 0);
      chk("t7_csum_cnt", csum_err_cnt, 0);
      chk("t7_frame_cnt", frame_err_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
